light_threshold: RTL and testbench

- Upstream stage of the light-streak velocity tracker.
- Converts the camera's RGB565 pixel stream to 8-bit luma, then thresholds it with per-row hysteresis.
- Emits the valid/light/x/y beat stream the tracker consumes, fully pipelined at one pixel per clock.
- Thresholds are sampled only at frame start, so they never change mid-frame.

---
 rtl/light_threshold.sv | 238 +++++++++++++++++++++++
 tb/tb_light_threshold.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/light_threshold.sv
// light_threshold: RGB565 -> 8-bit luma -> per-row hysteresis threshold, one pixel per clock.
// Latency: 3 cycles (S1 channel expand, S2 luma, S3 classify); bubbles propagate as valid=0.
// Backpressure: none; a beat is accepted every cycle. Optional counter: define LIGHT_COUNT_EN.
module light_threshold #(
    parameter logic [7:0] DEFAULT_HI = 8'd200,
    parameter logic [7:0] DEFAULT_LO = 8'd160,
    parameter int         COUNT_W    = 21
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic [15:0]        pixel_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic [7:0]         thresh_hi_in,
    input  logic [7:0]         thresh_lo_in,
    output logic               valid_out,
    output logic               light_out,
    output logic [10:0]        x_out,
    output logic [9:0]         y_out,
    output logic [7:0]         luma_out
`ifdef LIGHT_COUNT_EN
    ,
    output logic [COUNT_W-1:0] count_out,
    output logic               count_valid_out
`endif
);

    // A zero-width counter makes no sense even when the counter is compiled out.
    generate
        if (COUNT_W < 1) begin : g_count_w_check
            $error("light_threshold: COUNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic {
        ROW_OFF = 1'b0,
        ROW_ON  = 1'b1
    } row_state_t;

    // ------------------------------------------------------------------
    // Threshold selection at pipeline entry
    // ------------------------------------------------------------------
    // The frame-start beat itself must already see the fresh thresholds, so
    // the value carried down the pipe is muxed from the live inputs on that
    // beat. Each beat carries its own thresholds, which keeps beats that are
    // still in flight from the previous frame on the old values.
    logic [7:0] thr_hi;
    logic [7:0] thr_lo;
    logic       frame_start_in;
    logic [7:0] hi_sel;
    logic [7:0] lo_sel;
    logic [7:0] lo_eff_sel;

    // Pick raw thresholds for the entering beat and clamp lo to at most hi.
    always_comb begin
        frame_start_in = valid_in && (x_in == 11'd0) && (y_in == 10'd0);
        hi_sel         = frame_start_in ? thresh_hi_in : thr_hi;
        lo_sel         = frame_start_in ? thresh_lo_in : thr_lo;
        lo_eff_sel     = (lo_sel < hi_sel) ? lo_sel : hi_sel;
    end

    // Latched thresholds: load defaults on reset, sample only at frame start.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            thr_hi <= DEFAULT_HI;
            thr_lo <= DEFAULT_LO;
        end else if (frame_start_in) begin
            thr_hi <= thresh_hi_in;
            thr_lo <= thresh_lo_in;
        end
    end

    // ------------------------------------------------------------------
    // S1: channel expansion to 8 bits by replicating the top bits
    // ------------------------------------------------------------------
    logic        s1_vld;
    logic [7:0]  s1_r;
    logic [7:0]  s1_g;
    logic [7:0]  s1_b;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;
    logic [7:0]  s1_hi;
    logic [7:0]  s1_lo;

    // S1 register: valid always advances, payload loads only on valid beats.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_vld <= 1'b0;
            s1_r   <= 8'd0;
            s1_g   <= 8'd0;
            s1_b   <= 8'd0;
            s1_x   <= 11'd0;
            s1_y   <= 10'd0;
            s1_hi  <= 8'd0;
            s1_lo  <= 8'd0;
        end else begin
            s1_vld <= valid_in;
            if (valid_in) begin
                s1_r  <= {pixel_in[15:11], pixel_in[15:13]};
                s1_g  <= {pixel_in[10:5],  pixel_in[10:9]};
                s1_b  <= {pixel_in[4:0],   pixel_in[4:2]};
                s1_x  <= x_in;
                s1_y  <= y_in;
                s1_hi <= hi_sel;
                s1_lo <= lo_eff_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: luma = (77 R + 150 G + 29 B) >> 8, truncated
    // ------------------------------------------------------------------
    // Coefficients sum to 256, so the worst case is 255*256 = 65280 and the
    // 16-bit sum cannot overflow.
    logic [15:0] luma_sum;

    // Weighted channel sum, all operands widened to 16 bits.
    always_comb begin
        luma_sum = 16'd77  * {8'd0, s1_r}
                 + 16'd150 * {8'd0, s1_g}
                 + 16'd29  * {8'd0, s1_b};
    end

    logic        s2_vld;
    logic [7:0]  s2_luma;
    logic [10:0] s2_x;
    logic [9:0]  s2_y;
    logic [7:0]  s2_hi;
    logic [7:0]  s2_lo;

    // S2 register: keep the upper byte of the sum, carry coordinates along.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s2_vld  <= 1'b0;
            s2_luma <= 8'd0;
            s2_x    <= 11'd0;
            s2_y    <= 10'd0;
            s2_hi   <= 8'd0;
            s2_lo   <= 8'd0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_luma <= luma_sum[15:8];
                s2_x    <= s1_x;
                s2_y    <= s1_y;
                s2_hi   <= s1_hi;
                s2_lo   <= s1_lo;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: hysteresis classification
    // ------------------------------------------------------------------
    row_state_t row_state;
    row_state_t row_state_nxt;
    logic       light_nxt;
    logic       was_on;

    // Hysteresis state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_state <= ROW_OFF;
        end else begin
            row_state <= row_state_nxt;
        end
    end

    // Classify the S2 beat; column 0 ignores the previous row's state.
    always_comb begin
        row_state_nxt = row_state;
        was_on        = (row_state == ROW_ON) && (s2_x != 11'd0);
        light_nxt     = was_on ? (s2_luma >= s2_lo) : (s2_luma >= s2_hi);
        if (s2_vld) begin
            row_state_nxt = light_nxt ? ROW_ON : ROW_OFF;
        end
    end

    // Output register: light is forced low on bubbles, payload holds.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            light_out <= 1'b0;
            x_out     <= 11'd0;
            y_out     <= 10'd0;
            luma_out  <= 8'd0;
        end else begin
            valid_out <= s2_vld;
            light_out <= s2_vld && light_nxt;
            if (s2_vld) begin
                x_out    <= s2_x;
                y_out    <= s2_y;
                luma_out <= s2_luma;
            end
        end
    end

`ifdef LIGHT_COUNT_EN
    // ------------------------------------------------------------------
    // Bright-pixel counter, reported once per frame at the next frame start
    // ------------------------------------------------------------------
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    logic               frame_start_s3;
    logic               seen_frame;
    logic [COUNT_W-1:0] bright_cnt;

    // Frame start as seen by the classify stage.
    always_comb begin
        frame_start_s3 = s2_vld && (s2_x == 11'd0) && (s2_y == 10'd0);
    end

    // Accumulate saturating count; publish and restart on each frame start.
    // The first frame start after reset has no complete frame behind it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            seen_frame      <= 1'b0;
            bright_cnt      <= '0;
            count_out       <= '0;
            count_valid_out <= 1'b0;
        end else begin
            count_valid_out <= 1'b0;
            if (frame_start_s3) begin
                seen_frame <= 1'b1;
                bright_cnt <= light_nxt ? COUNT_W'(1) : '0;
                if (seen_frame) begin
                    count_out       <= bright_cnt;
                    count_valid_out <= 1'b1;
                end
            end else if (s2_vld && light_nxt && (bright_cnt != COUNT_MAX)) begin
                bright_cnt <= bright_cnt + COUNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_light_threshold.sv
// Directed testbench for light_threshold: luma, hysteresis, row reset, threshold timing, bubbles, reset.
// Inputs change on the falling edge; each beat() call spans one clock, so outputs lag two calls.
// Counter checks are compiled only when LIGHT_COUNT_EN is defined.
module tb_light_threshold;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic [15:0] pixel_in;
    logic [10:0] x_in;
    logic [9:0]  y_in;
    logic [7:0]  thresh_hi_in;
    logic [7:0]  thresh_lo_in;
    logic        valid_out;
    logic        light_out;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic [7:0]  luma_out;
`ifdef LIGHT_COUNT_EN
    logic [20:0] count_out;
    logic        count_valid_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    light_threshold dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .valid_in     (valid_in),
        .pixel_in     (pixel_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .thresh_hi_in (thresh_hi_in),
        .thresh_lo_in (thresh_lo_in),
        .valid_out    (valid_out),
        .light_out    (light_out),
        .x_out        (x_out),
        .y_out        (y_out),
        .luma_out     (luma_out)
`ifdef LIGHT_COUNT_EN
        ,
        .count_out       (count_out),
        .count_valid_out (count_valid_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [15:0] p, input logic [10:0] x, input logic [9:0] y);
        valid_in = v;
        pixel_in = p;
        x_in     = x;
        y_in     = y;
        @(negedge clk_in);
    endtask

    task automatic bubble();
        beat(1'b0, 16'h1234, 11'd99, 10'd99);
    endtask

`ifdef LIGHT_COUNT_EN
    logic [15:0] frame_px [8];
    int          other_pulses;
`endif

    initial begin
        rst_in       = 1'b1;
        valid_in     = 1'b0;
        pixel_in     = 16'h0000;
        x_in         = 11'd0;
        y_in         = 10'd0;
        thresh_hi_in = 8'd200;
        thresh_lo_in = 8'd100;

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_valid", valid_out, 0);
        chk("rst_light", light_out, 0);
        chk("rst_luma",  luma_out,  0);
        chk("rst_x",     x_out,     0);
        chk("rst_y",     y_out,     0);
`ifdef LIGHT_COUNT_EN
        chk("rst_count",  count_out,       0);
        chk("rst_cvalid", count_valid_out, 0);
`endif
        rst_in = 1'b0;

        // Luma of saturated colours, default thresholds 200/160, not a frame start
        beat(1'b1, 16'hFFFF, 11'd10, 10'd1);
        beat(1'b1, 16'h0000, 11'd11, 10'd1);
        chk("early_valid", valid_out, 0);
        beat(1'b1, 16'hF800, 11'd12, 10'd1);
        chk("luma_white", luma_out, 255);
        chk("light_white", light_out, 1);
        chk("x_white", x_out, 10);
        beat(1'b1, 16'h07E0, 11'd13, 10'd1);
        chk("luma_black", luma_out, 0);
        bubble();
        chk("luma_red", luma_out, 76);
        bubble();
        chk("luma_green", luma_out, 149);
        chk("light_green_dflt", light_out, 0);
        bubble();
        chk("bubble_valid", valid_out, 0);
        chk("bubble_light", light_out, 0);
        chk("bubble_luma_hold", luma_out, 149);
        chk("bubble_x_hold", x_out, 13);

        // Frame start latches 200/100; row hysteresis then row reset
        beat(1'b1, 16'h0000, 11'd0, 10'd0);
        beat(1'b1, 16'hFFFF, 11'd0, 10'd5);
        beat(1'b1, 16'h07E0, 11'd1, 10'd5);
        chk("fs_light", light_out, 0);
        beat(1'b1, 16'hF800, 11'd2, 10'd5);
        chk("hyst_x0", light_out, 1);
        beat(1'b1, 16'h07E0, 11'd3, 10'd5);
        chk("hyst_x1_stay_on", light_out, 1);
        beat(1'b1, 16'hFFFF, 11'd4, 10'd5);
        chk("hyst_x2_drop", light_out, 0);
        chk("hyst_x2_luma", luma_out, 76);
        beat(1'b1, 16'h07E0, 11'd0, 10'd6);
        chk("hyst_x3_off", light_out, 0);
        bubble();
        chk("row_last", light_out, 1);
        chk("row_last_x", x_out, 4);
        bubble();
        chk("row_start_off", light_out, 0);
        chk("row_start_y", y_out, 6);
        chk("row_start_x", x_out, 0);

        // Thresholds change mid-frame only take effect at the next frame start
        thresh_hi_in = 8'd255;
        beat(1'b1, 16'h0000, 11'd0, 10'd0);
        thresh_hi_in = 8'd100;
        beat(1'b1, 16'h07E0, 11'd1, 10'd0);
        beat(1'b1, 16'h0000, 11'd0, 10'd0);
        beat(1'b1, 16'h07E0, 11'd1, 10'd0);
        chk("thr_before_fs", light_out, 0);
        bubble();
        bubble();
        chk("thr_after_fs", light_out, 1);

        // Bubble pattern 1,0,1,1
        beat(1'b1, 16'hFFFF, 11'd20, 10'd3);
        chk("pat_pre0", valid_out, 0);
        bubble();
        chk("pat_pre1", valid_out, 0);
        beat(1'b1, 16'hFFFF, 11'd22, 10'd3);
        chk("pat_v0", valid_out, 1);
        beat(1'b1, 16'hFFFF, 11'd23, 10'd3);
        chk("pat_v1", valid_out, 0);
        chk("pat_l1", light_out, 0);
        chk("pat_x1_hold", x_out, 20);
        bubble();
        chk("pat_v2", valid_out, 1);
        bubble();
        chk("pat_v3", valid_out, 1);
        chk("pat_x3", x_out, 23);

        // Reset with beats in flight
        beat(1'b1, 16'hFFFF, 11'd30, 10'd7);
        beat(1'b1, 16'hFFFF, 11'd31, 10'd7);
        beat(1'b1, 16'hFFFF, 11'd32, 10'd7);
        chk("flight_valid", valid_out, 1);
        chk("flight_x", x_out, 30);
        valid_in = 1'b0;
        rst_in   = 1'b1;
        #1;
        chk("rst_async_valid", valid_out, 0);
        chk("rst_async_light", light_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bubble();
            chk("no_stale", valid_out, 0);
        end

        // After reset the defaults 200/160 apply until a frame start
        beat(1'b1, 16'h07E0, 11'd5, 10'd2);
        beat(1'b1, 16'hFFFF, 11'd6, 10'd2);
        beat(1'b1, 16'hB5B6, 11'd7, 10'd2);
        chk("dflt_hi_off", light_out, 0);
        beat(1'b1, 16'h07E0, 11'd8, 10'd2);
        chk("dflt_hi_on", light_out, 1);
        bubble();
        chk("dflt_gray_luma", luma_out, 181);
        chk("dflt_lo_hold", light_out, 1);
        bubble();
        chk("dflt_lo_drop", light_out, 0);

`ifdef LIGHT_COUNT_EN
        // 4x2 frame with three bright pixels, then a second frame start
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in       = 1'b0;
        thresh_hi_in = 8'd200;
        thresh_lo_in = 8'd100;
        frame_px     = '{16'h0000, 16'hFFFF, 16'h0000, 16'h0000,
                         16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        other_pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k < 8)
                beat(1'b1, frame_px[k], 11'(k % 4), 10'(k / 4));
            else if (k == 8)
                beat(1'b1, 16'h0000, 11'd0, 10'd0);
            else
                bubble();
            if (k == 10) begin
                chk("cnt_pulse", count_valid_out, 1);
                chk("cnt_value", count_out, 3);
            end else if (count_valid_out) begin
                other_pulses++;
            end
        end
        chk("cnt_no_extra_pulse", other_pulses, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
